// File: rtl/fb_writer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : fb_writer
// Description : Pixel-stream to framebuffer write engine. Drawing pixels are
//               clipped against the screen, buffered in a small FIFO and
//               issued one per cycle as address/data write requests held
//               until granted. A clear request waits for outstanding pixels
//               to retire and then sweeps the whole framebuffer with a fill
//               colour.
//
// Ports       : clk           - single clock, all state on rising edge
//               resetn        - asynchronous active-low reset
//               x_stream      - pixel x coordinate (9 bits)
//               y_stream      - pixel y coordinate (8 bits)
//               color_stream  - pixel colour (3 bits)
//               writeEn       - producer strobe, one pixel per high cycle
//               ready         - a pixel offered this cycle will be accepted
//               clear         - request full-screen fill
//               clear_color   - fill colour, sampled when clear is accepted
//               mem_addr      - framebuffer word address (y*SCREEN_W + x)
//               mem_data      - framebuffer write data
//               mem_we        - write request, held until granted
//               mem_grant     - memory accepts the write when high with mem_we
//               busy          - pixel or clear work outstanding
//               clip_count    - saturating count of off-screen pixels dropped
//               drop_count    - saturating count of pixels offered while !ready
//
// Revision    : 1.0 - initial release
// ============================================================================
module fb_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 240
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  x_stream,
    input  logic [7:0]  y_stream,
    input  logic [2:0]  color_stream,
    input  logic        writeEn,
    output logic        ready,
    input  logic        clear,
    input  logic [2:0]  clear_color,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_grant,
    output logic        busy,
    output logic [7:0]  clip_count,
    output logic [7:0]  drop_count
);

    localparam int unsigned c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_ENTRY_W   = 20;  // {x[8:0], y[7:0], colour[2:0]}
    localparam logic [16:0] c_LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // output register empty
        S_DRAW  = 2'd1,   // output register holds a pixel write
        S_CLEAR = 2'd2    // fill sweep in progress
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_clear_pending;
    logic [2:0]             r_clear_color;
    logic [16:0]            r_mem_addr;
    logic [2:0]             r_mem_data;
    logic                   r_mem_we;
    logic [7:0]             r_clip_count;
    logic [7:0]             r_drop_count;

    logic [c_ENTRY_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W:0]       r_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                   w_on_screen;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_clip;
    logic                   w_drop;
    logic                   w_retire;
    logic [c_ENTRY_W-1:0]   w_head;
    logic [8:0]             w_head_x;
    logic [7:0]             w_head_y;
    logic [2:0]             w_head_c;
    logic [16:0]            w_head_addr;

    assign w_on_screen  = (32'(x_stream) < SCREEN_W) && (32'(y_stream) < SCREEN_H);
    assign w_fifo_empty = (r_count == '0);
    // Fullness ignores a same-cycle pop: a full FIFO never accepts.
    assign w_fifo_full  = (32'(r_count) >= FIFO_DEPTH);

    // The pending flag stays set for the whole sweep, so it also covers CLEAR.
    assign w_ready  = resetn & ~w_fifo_full & ~r_clear_pending & (r_state != S_CLEAR);

    assign w_push   = writeEn &  w_ready &  w_on_screen;
    assign w_clip   = writeEn &  w_ready & ~w_on_screen;
    assign w_drop   = writeEn & ~w_ready;
    assign w_retire = r_mem_we & mem_grant;

    // The head is consumed whenever the output register is free or freeing.
    assign w_pop    = ~w_fifo_empty &
                      ((r_state == S_IDLE) | ((r_state == S_DRAW) & w_retire));

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_head_x = w_head[19:11];
    assign w_head_y = w_head[10:3];
    assign w_head_c = w_head[2:0];

    // Linear address of the FIFO head. The default 320-pixel width reduces to
    // y*256 + y*64 + x, so no multiplier is needed there.
    generate
        if (SCREEN_W == 320) begin : g_addr_shift
            assign w_head_addr = ({9'd0, w_head_y} << 8) +
                                 ({9'd0, w_head_y} << 6) +
                                 {8'd0, w_head_x};
        end else begin : g_addr_mul
            assign w_head_addr = 17'(32'(w_head_y) * SCREEN_W + 32'(w_head_x));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {x_stream, y_stream, color_stream};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_clear_pending <= 1'b0;
            r_clear_color   <= 3'd0;
            r_mem_addr      <= 17'd0;
            r_mem_data      <= 3'd0;
            r_mem_we        <= 1'b0;
        end else begin
            // A clear is latched once; repeats are ignored until the sweep
            // finishes and the flag drops on the return to IDLE.
            if (clear && !r_clear_pending && (r_state != S_CLEAR)) begin
                r_clear_pending <= 1'b1;
                r_clear_color   <= clear_color;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_mem_addr <= w_head_addr;
                        r_mem_data <= w_head_c;
                        r_mem_we   <= 1'b1;
                        r_state    <= S_DRAW;
                    end else if (r_clear_pending) begin
                        // All pixels retired: start the sweep at address 0.
                        r_mem_addr <= 17'd0;
                        r_mem_data <= r_clear_color;
                        r_mem_we   <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end

                S_DRAW: begin
                    // Address/data only move when the current write retires.
                    if (w_retire) begin
                        if (!w_fifo_empty) begin
                            r_mem_addr <= w_head_addr;
                            r_mem_data <= w_head_c;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end

                S_CLEAR: begin
                    if (mem_grant) begin
                        if (r_mem_addr == c_LAST_ADDR) begin
                            r_mem_we        <= 1'b0;
                            r_clear_pending <= 1'b0;
                            r_state         <= S_IDLE;
                        end else begin
                            r_mem_addr <= r_mem_addr + 17'd1;
                        end
                    end
                end

                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating discard counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clip_count <= 8'd0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_clip && (r_clip_count != 8'hFF)) begin
                r_clip_count <= r_clip_count + 8'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready      = w_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;
    assign busy       = (r_state != S_IDLE) | ~w_fifo_empty | r_clear_pending;
    assign clip_count = r_clip_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_fb_writer
// Description : Directed self-checking bench for fb_writer. Expected writes
//               are queued as stimulus is applied and compared in order as
//               the DUT's granted writes appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

    logic        clk;
    logic        resetn;
    logic [8:0]  x_stream;
    logic [7:0]  y_stream;
    logic [2:0]  color_stream;
    logic        writeEn;
    logic        ready;
    logic        clear;
    logic [2:0]  clear_color;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_grant;
    logic        busy;
    logic [7:0]  clip_count;
    logic [7:0]  drop_count;

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  errors = 0;

    fb_writer dut (
        .clk          (clk),
        .resetn       (resetn),
        .x_stream     (x_stream),
        .y_stream     (y_stream),
        .color_stream (color_stream),
        .writeEn      (writeEn),
        .ready        (ready),
        .clear        (clear),
        .clear_color  (clear_color),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_grant    (mem_grant),
        .busy         (busy),
        .clip_count   (clip_count),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: a write is taken on the rising edge following a falling
    // edge where mem_we and mem_grant are both high (inputs only change just
    // after rising edges).
    logic        prev_valid = 1'b0;
    logic        prev_we    = 1'b0;
    logic        prev_grant = 1'b0;
    logic [16:0] prev_addr  = '0;
    logic [2:0]  prev_data  = '0;
    wr_t         exp_w;

    always @(negedge clk) begin
        if (resetn) begin
            if (prev_valid && prev_we && !prev_grant) begin
                check("hold_we",   32'(mem_we),   32'(1));
                check("hold_addr", 32'(mem_addr), 32'(prev_addr));
                check("hold_data", 32'(mem_data), 32'(prev_data));
            end
            if (mem_we && mem_grant) begin
                // Empty queue -> sentinel address no legal write can carry.
                exp_w = (q.size() > 0) ? q.pop_front() : '1;
                check("write_addr", 32'(mem_addr), 32'(exp_w.addr));
                check("write_data", 32'(mem_data), 32'(exp_w.data));
            end
            prev_valid = 1'b1;
            prev_we    = mem_we;
            prev_grant = mem_grant;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn       = 1'b0;
        x_stream     = '0;
        y_stream     = '0;
        color_stream = '0;
        writeEn      = 1'b0;
        clear        = 1'b0;
        clear_color  = '0;
        mem_grant    = 1'b0;

        // ---------------- reset state ----------------
        #5;
        check("rst_we",    32'(mem_we),     32'(0));
        check("rst_addr",  32'(mem_addr),   32'(0));
        check("rst_data",  32'(mem_data),   32'(0));
        check("rst_busy",  32'(busy),       32'(0));
        check("rst_ready", 32'(ready),      32'(0));
        check("rst_clip",  32'(clip_count), 32'(0));
        check("rst_drop",  32'(drop_count), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        check("ready_after_release", 32'(ready), 32'(1));

        // ---------------- single pixel latency ----------------
        mem_grant    = 1'b1;
        x_stream     = 9'd5;
        y_stream     = 8'd2;
        color_stream = 3'd3;
        writeEn      = 1'b1;
        q.push_back({17'd645, 3'd3});
        tick();
        writeEn = 1'b0;
        check("single_edgeN_we",   32'(mem_we), 32'(0));
        check("single_edgeN_busy", 32'(busy),   32'(1));
        tick();
        check("single_we",   32'(mem_we),   32'(1));
        check("single_addr", 32'(mem_addr), 32'(645));
        check("single_data", 32'(mem_data), 32'(3));
        tick();
        check("single_busy_done", 32'(busy),   32'(0));
        check("single_we_done",   32'(mem_we), 32'(0));

        // ---------------- back-pressure burst ----------------
        mem_grant = 1'b0;
        for (int i = 0; i < 12; i++) begin
            x_stream     = 9'(i * 10);
            y_stream     = 8'(i + 1);
            color_stream = 3'(i);
            writeEn      = 1'b1;
            check("burst_ready", 32'(ready), 32'(int'(i < 9)));
            if (i < 9) q.push_back({17'((i + 1) * 320 + i * 10), 3'(i)});
            tick();
        end
        writeEn = 1'b0;
        check("burst_drop",  32'(drop_count), 32'(3));
        check("burst_ready_low", 32'(ready),  32'(0));
        check("burst_head_we",   32'(mem_we),   32'(1));
        check("burst_head_addr", 32'(mem_addr), 32'(320));
        repeat (5) tick();
        mem_grant = 1'b1;
        for (int k = 0; k < 50 && (q.size() != 0 || busy); k++) tick();
        check("burst_drained", 32'(q.size()), 32'(0));
        check("burst_busy",    32'(busy),     32'(0));

        // ---------------- clipping ----------------
        x_stream = 9'd320; y_stream = 8'd0;   writeEn = 1'b1;
        tick();
        x_stream = 9'd0;   y_stream = 8'd240;
        tick();
        writeEn = 1'b0;
        repeat (3) tick();
        check("clip_two",    32'(clip_count), 32'(2));
        check("clip_no_we",  32'(mem_we),     32'(0));
        check("clip_busy",   32'(busy),       32'(0));
        for (int k = 0; k < 298; k++) begin
            if (k % 2 == 0) begin
                x_stream = 9'(320 + $urandom_range(0, 191));
                y_stream = 8'($urandom_range(0, 255));
            end else begin
                x_stream = 9'($urandom_range(0, 319));
                y_stream = 8'(240 + $urandom_range(0, 15));
            end
            writeEn = 1'b1;
            tick();
        end
        writeEn = 1'b0;
        tick();
        check("clip_saturate", 32'(clip_count), 32'(255));
        check("clip_drop_kept", 32'(drop_count), 32'(3));
        check("clip_no_we2",   32'(mem_we),     32'(0));

        // ---------------- clear behind queued pixels ----------------
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_stream     = 9'(100 + i);
            y_stream     = 8'(50 + i);
            color_stream = 3'(i + 1);
            writeEn      = 1'b1;
            q.push_back({17'((50 + i) * 320 + 100 + i), 3'(i + 1)});
            tick();
        end
        writeEn     = 1'b0;
        clear       = 1'b1;
        clear_color = 3'd5;
        tick();
        clear = 1'b0;
        for (int a = 0; a < 76800; a++) q.push_back({17'(a), 3'd5});
        check("clear_busy", 32'(busy), 32'(1));
        repeat (4) begin
            check("clear_wait_ready", 32'(ready), 32'(0));
            tick();
        end
        mem_grant = 1'b1;
        for (int k = 0; k < 80000; k++) begin
            tick();
            if (q.size() == 0) break;
            check("clear_sweep_ready", 32'(ready), 32'(0));
            if (k == 5000) begin
                clear       = 1'b1;   // repeat request mid-sweep: ignored
                clear_color = 3'd2;
            end else begin
                clear = 1'b0;
            end
        end
        clear = 1'b0;
        check("clear_drained", 32'(q.size()), 32'(0));
        tick();
        check("clear_done_busy",  32'(busy),   32'(0));
        check("clear_done_we",    32'(mem_we), 32'(0));
        check("clear_done_ready", 32'(ready),  32'(1));
        repeat (5) tick();
        check("clear_no_resweep", 32'(mem_we), 32'(0));

        // ---------------- reset mid-sweep ----------------
        clear       = 1'b1;
        clear_color = 3'd6;
        tick();
        clear = 1'b0;
        for (int a = 0; a < 1000; a++) q.push_back({17'(a), 3'd6});
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (mem_we && mem_addr == 17'd1000) break;
        end
        check("abort_reached_1000", 32'(mem_addr), 32'(1000));
        #2 resetn = 1'b0;
        #1;
        check("abort_we",    32'(mem_we),     32'(0));
        check("abort_addr",  32'(mem_addr),   32'(0));
        check("abort_data",  32'(mem_data),   32'(0));
        check("abort_busy",  32'(busy),       32'(0));
        check("abort_ready", 32'(ready),      32'(0));
        check("abort_clip",  32'(clip_count), 32'(0));
        check("abort_drop",  32'(drop_count), 32'(0));
        check("abort_queue", 32'(q.size()),   32'(0));
        q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        check("abort_ready_release", 32'(ready),  32'(1));
        check("abort_we_release",    32'(mem_we), 32'(0));
        repeat (20) begin
            tick();
            check("abort_no_write", 32'(mem_we), 32'(0));
        end
        check("abort_idle_busy", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
